mips_harvard_cpu: RTL and testbench
===================================

MIPS_HARVARD_CPU -- requirements
Module: mips_harvard_cpu

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL provide: reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL provide: active  out  1  high while executing; low once halted.
REQ-004 SHALL provide: register_v0  out  32  current contents of GPR $2, combinational from the register file.
REQ-005 SHALL provide: clk_enable  in  1  when low, all architectural state holds.
REQ-006 SHALL provide: instr_address  out  32  byte address of the current instruction, equal to the PC.
REQ-007 SHALL provide: instr_readdata  in  32  instruction word, valid combinationally in the same cycle as instr_address.
REQ-008 SHALL provide: data_address  out  32  load/store byte address.
REQ-009 SHALL provide: data_write  out  1  store strobe; memory writes on the rising clk edge.
REQ-010 SHALL provide: data_read  out  1  load strobe.
REQ-011 SHALL provide: data_writedata  out  32  store data (rt).
REQ-012 SHALL provide: data_readdata  in  32  load data, valid combinationally in the same cycle as data_address.

Function
REQ-013 SHALL be a single-cycle MIPS32 (little-endian, word-only) core: one instruction completes per enabled clock.
REQ-014 SHALL hold 32 x 32-bit GPRs; $0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-015 SHALL implement R-type ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
REQ-016 SHALL implement I/J-type ADDIU, SLTI, SLTIU (sign-extended immediate), ANDI, ORI, XORI (zero-extended), LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-017 LUI SHALL write {imm16, 16'h0} to rt.
REQ-018 ADDU/ADDIU/SUBU SHALL wrap modulo 2^32 and SHALL NOT trap; SLT/SLTI SHALL compare signed, and SLTU/SLTIU SHALL compare unsigned.
REQ-019 Branches and jumps SHALL have exactly one architectural delay slot, and the delay-slot instruction SHALL always execute.
REQ-020 The branch target SHALL be (PC+4) + (sext(imm16) << 2); the J target SHALL be {(PC+4)[31:28], imm26, 2'b00}.
REQ-021 JAL SHALL write PC+8 to $31; JALR SHALL write PC+8 to rd.
REQ-022 The core SHALL track the PC and the next PC; on each enabled edge, PC <= next PC, and next PC <= jump/branch target if taken, else next PC + 4.
REQ-023 LW SHALL assert data_read, drive data_address = rs + sext(imm16), and write data_readdata to rt at the clk edge.
REQ-024 SW SHALL assert data_write and drive data_writedata = rt.
REQ-025 data_read and data_write SHALL be 0 for all other instructions, while in reset, while halted, and while clk_enable = 0.
REQ-026 Unrecognised opcodes/functs SHALL execute as NOPs.
REQ-027 Halt: when the PC becomes 32'h00000000 (after the delay slot of a jump to address 0), active SHALL drop to 0 on that edge.
REQ-028 Once halted, the PC SHALL stay 0, and no register or memory writes SHALL occur until reset.
REQ-029 clk_enable = 0 SHALL freeze the PC, next PC, GPRs and active; register_v0 SHALL keep reflecting $2.

Reset
REQ-030 On a rising clk with reset = 0: PC SHALL be 32'hBFC00000, next PC 32'hBFC00004, all GPRs 0, active 1.
REQ-031 Reset SHALL override clk_enable and halt state.
REQ-032 Reset SHALL take effect mid-instruction, discarding any pending branch target.
REQ-033 After reset, instr_address SHALL equal 32'hBFC00000 until the first enabled post-reset edge.

Verification
REQ-034 Program at BFC00000: LUI $1,1; LUI $3,4; ADDU $2,$1,$3; JR $0; ADDIU $0,$0,0 -> when instr_address == 0, register_v0 == 32'h00050000 and active == 0.
REQ-035 Assert reset for 1 clk mid-program -> next instr_address == BFC00000, register_v0 == 0, active == 1.
REQ-036 ORI $1,$0,0x1234; SW $1,8($0); LW $2,8($0) -> data_write pulses 1 cycle at address 8; register_v0 == 0x1234.
REQ-037 BEQ $0,$0,+2 followed by ADDIU $2,$0,7 in the delay slot -> delay slot executes (v0 == 7), then the PC equals the target.
REQ-038 ADDIU $0,$0,5; ADDU $2,$0,$0 -> v0 == 0; ADDIU $2,$0,-1; ADDIU $2,$2,1 -> v0 == 0 (wrap).
REQ-039 Hold clk_enable = 0 for 3 clks mid-program -> instr_address and v0 unchanged, no data strobes; execution resumes unchanged afterwards.

Source files
------------

// File: rtl/mips_harvard_cpu.sv
// rtl/mips_harvard_cpu.sv - single-cycle MIPS32 subset core with separate instruction and data ports
module mips_harvard_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] gpr [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        go;

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic        taken;
    logic [31:0] target;

    assign {opcode, rs, rt, rd, shamt, funct} = instr_readdata;

    // $0 is never written and resets to zero, so a plain read is sufficient
    assign rs_val        = gpr[rs];
    assign rt_val        = gpr[rt];
    assign sext_imm      = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign zext_imm      = {16'h0000, instr_readdata[15:0]};
    assign pc_plus4      = pc + 32'd4;
    assign pc_plus8      = pc + 32'd8;
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

    assign go             = reset && clk_enable && active;
    assign instr_address  = pc;
    assign register_v0    = gpr[2];
    assign data_address   = rs_val + sext_imm;
    assign data_writedata = rt_val;
    assign data_read      = go && (opcode == 6'h23);
    assign data_write     = go && (opcode == 6'h2B);

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rt;
        wr_data = 32'h0;
        taken   = 1'b0;
        target  = branch_target;
        case (opcode)
            6'h00: begin
                wr_idx = rd;
                wr_en  = 1'b1;
                case (funct)
                    6'h00: wr_data = rt_val << shamt;
                    6'h02: wr_data = rt_val >> shamt;
                    6'h03: wr_data = $signed(rt_val) >>> shamt;
                    6'h04: wr_data = rt_val << rs_val[4:0];
                    6'h06: wr_data = rt_val >> rs_val[4:0];
                    6'h07: wr_data = $signed(rt_val) >>> rs_val[4:0];
                    6'h08: begin wr_en = 1'b0; taken = 1'b1; target = rs_val; end
                    6'h09: begin taken = 1'b1; target = rs_val; wr_data = pc_plus8; end
                    6'h21: wr_data = rs_val + rt_val;
                    6'h23: wr_data = rs_val - rt_val;
                    6'h24: wr_data = rs_val & rt_val;
                    6'h25: wr_data = rs_val | rt_val;
                    6'h26: wr_data = rs_val ^ rt_val;
                    6'h27: wr_data = ~(rs_val | rt_val);
                    6'h2A: wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: wr_data = {31'h0, rs_val < rt_val};
                    default: wr_en = 1'b0;
                endcase
            end
            6'h02: begin taken = 1'b1; target = jump_target; end
            6'h03: begin
                taken = 1'b1; target = jump_target;
                wr_en = 1'b1; wr_idx = 5'd31; wr_data = pc_plus8;
            end
            6'h04: taken = (rs_val == rt_val);
            6'h05: taken = (rs_val != rt_val);
            6'h09: begin wr_en = 1'b1; wr_data = rs_val + sext_imm; end
            6'h0A: begin wr_en = 1'b1; wr_data = {31'h0, $signed(rs_val) < $signed(sext_imm)}; end
            6'h0B: begin wr_en = 1'b1; wr_data = {31'h0, rs_val < sext_imm}; end
            6'h0C: begin wr_en = 1'b1; wr_data = rs_val & zext_imm; end
            6'h0D: begin wr_en = 1'b1; wr_data = rs_val | zext_imm; end
            6'h0E: begin wr_en = 1'b1; wr_data = rs_val ^ zext_imm; end
            6'h0F: begin wr_en = 1'b1; wr_data = {instr_readdata[15:0], 16'h0000}; end
            6'h23: begin wr_en = 1'b1; wr_data = data_readdata; end
            default: ;
        endcase
    end

    // The halted state is simply active == 0: PC is already 0 and nothing advances
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_VECTOR;
            npc    <= RESET_VECTOR + 32'd4;
            active <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= 32'h0;
            end
        end else if (clk_enable && active) begin
            pc  <= npc;
            npc <= taken ? target : npc + 32'd4;
            if (npc == 32'h0) begin
                active <= 1'b0;
            end
            if (wr_en && (wr_idx != 5'd0)) begin
                gpr[wr_idx] <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// tb/tb_mips_harvard_cpu.sv - directed and randomized program checks against an ISA-level model
module tb_mips_harvard_cpu;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic        active;
    logic        data_write;
    logic        data_read;
    logic [31:0] register_v0;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic [31:0] prog [64];
    logic [31:0] dmem [64];
    logic [31:0] seed [64];
    logic        mem_load = 1'b0;
    logic [31:0] rom_off;
    logic        in_rom;

    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic        m_active;
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];

    int n_tests = 0;
    int n_fail  = 0;

    mips_harvard_cpu dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    assign rom_off        = instr_address - BASE;
    assign in_rom         = (instr_address >= BASE) && (instr_address < BASE + 32'd256);
    assign instr_readdata = in_rom ? prog[rom_off[7:2]] : 32'h0;
    assign data_readdata  = dmem[data_address[7:2]];

    initial forever begin
        @(posedge clk);
        if (mem_load) begin
            for (int i = 0; i < 64; i++) dmem[i] = seed[i];
        end else if (data_write) begin
            dmem[data_address[7:2]] = data_writedata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int sh, input int fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
        return {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int op, input int idx);
        logic [31:0] a;
        a = BASE + 32'(4 * idx);
        return {6'(op), a[27:2]};
    endfunction

    function automatic logic [31:0] fetch(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && a < BASE + 32'd256) return prog[off[7:2]];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_npc = BASE + 32'd4; m_active = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 64; i++) m_dmem[i] = seed[i];
    endtask

    // One architectural instruction: result, destination and the new next-PC
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, res, nxt, ea;
        int dst;
        ins = fetch(m_pc);
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        se  = 32'($signed(ins[15:0]));
        ze  = 32'(ins[15:0]);
        ea  = a + se;
        dst = 0; res = 32'h0; nxt = m_npc + 32'd4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h00: begin dst = ins[15:11]; res = b << ins[10:6]; end
                6'h02: begin dst = ins[15:11]; res = b >> ins[10:6]; end
                6'h03: begin dst = ins[15:11]; res = $signed(b) >>> ins[10:6]; end
                6'h04: begin dst = ins[15:11]; res = b << (a % 32); end
                6'h06: begin dst = ins[15:11]; res = b >> (a % 32); end
                6'h07: begin dst = ins[15:11]; res = $signed(b) >>> (a % 32); end
                6'h08: nxt = a;
                6'h09: begin nxt = a; dst = ins[15:11]; res = m_pc + 32'd8; end
                6'h21: begin dst = ins[15:11]; res = a + b; end
                6'h23: begin dst = ins[15:11]; res = a - b; end
                6'h24: begin dst = ins[15:11]; res = a & b; end
                6'h25: begin dst = ins[15:11]; res = a | b; end
                6'h26: begin dst = ins[15:11]; res = a ^ b; end
                6'h27: begin dst = ins[15:11]; res = ~(a | b); end
                6'h2A: begin dst = ins[15:11]; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h2B: begin dst = ins[15:11]; res = (a < b) ? 32'd1 : 32'd0; end
                default: ;
            endcase
            6'h02: nxt = {m_pc[31:28] + ((m_pc + 32'd4) >> 28) - m_pc[31:28], ins[25:0], 2'b00};
            6'h03: begin nxt = {((m_pc + 32'd4) >> 28) & 32'hF, ins[25:0], 2'b00} ; dst = 31; res = m_pc + 32'd8; end
            6'h04: if (a == b) nxt = m_pc + 32'd4 + se * 4;
            6'h05: if (a != b) nxt = m_pc + 32'd4 + se * 4;
            6'h09: begin dst = ins[20:16]; res = a + se; end
            6'h0A: begin dst = ins[20:16]; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0B: begin dst = ins[20:16]; res = (a < se) ? 32'd1 : 32'd0; end
            6'h0C: begin dst = ins[20:16]; res = a & ze; end
            6'h0D: begin dst = ins[20:16]; res = a | ze; end
            6'h0E: begin dst = ins[20:16]; res = a ^ ze; end
            6'h0F: begin dst = ins[20:16]; res = ze * 65536; end
            6'h23: begin dst = ins[20:16]; res = m_dmem[ea[7:2]]; end
            6'h2B: m_dmem[ea[7:2]] = b;
            default: ;
        endcase
        if (dst != 0) m_regs[dst] = res;
        m_pc  = m_npc;
        m_npc = nxt;
        if (m_pc == 32'h0) m_active = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; clk_enable = 1'b0; mem_load = 1'b1;
        @(negedge clk);
        reset = 1'b1; mem_load = 1'b0;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input int max_cycles, input int en_pct);
        int post;
        logic [31:0] ins, ea;
        logic exp_rd, exp_wr;
        post = 0;
        for (int c = 0; c < max_cycles && post < 3; c++) begin
            @(negedge clk);
            clk_enable = ($urandom_range(0, 99) < en_pct);
            #1;
            ins    = fetch(m_pc);
            ea     = m_regs[ins[25:21]] + 32'($signed(ins[15:0]));
            exp_rd = m_active && clk_enable && (ins[31:26] == 6'h23);
            exp_wr = m_active && clk_enable && (ins[31:26] == 6'h2B);
            chk("pc", instr_address, m_pc);
            chk("v0", register_v0, m_regs[2]);
            chk("active", 32'(active), 32'(m_active));
            chk("data_read", 32'(data_read), 32'(exp_rd));
            chk("data_write", 32'(data_write), 32'(exp_wr));
            if (exp_rd || exp_wr) chk("data_address", data_address, ea);
            if (exp_wr) chk("data_writedata", data_writedata, m_regs[ins[20:16]]);
            if (!m_active) post++;
            else if (clk_enable) model_step();
        end
        chk("halt_reached", 32'(active), 32'h0);
        clk_enable = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) chk("dmem", dmem[i], m_dmem[i]);
    endtask

    function automatic int rr();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 31 : r;
    endfunction

    function automatic logic [31:0] rand_plain();
        int k, s, t, d, imm, sh;
        k = $urandom_range(0, 24); s = rr(); t = rr(); d = rr();
        imm = $urandom_range(0, 65535); sh = $urandom_range(0, 31);
        case (k)
            0: return r_ins(s, t, d, 0, 'h21);
            1: return r_ins(s, t, d, 0, 'h23);
            2: return r_ins(s, t, d, 0, 'h24);
            3: return r_ins(s, t, d, 0, 'h25);
            4: return r_ins(s, t, d, 0, 'h26);
            5: return r_ins(s, t, d, 0, 'h27);
            6: return r_ins(s, t, d, 0, 'h2A);
            7: return r_ins(s, t, d, 0, 'h2B);
            8: return r_ins(0, t, d, sh, 'h00);
            9: return r_ins(0, t, d, sh, 'h02);
            10: return r_ins(0, t, d, sh, 'h03);
            11: return r_ins(s, t, d, 0, 'h04);
            12: return r_ins(s, t, d, 0, 'h06);
            13: return r_ins(s, t, d, 0, 'h07);
            14: return i_ins('h09, s, t, imm);
            15: return i_ins('h0A, s, t, imm);
            16: return i_ins('h0B, s, t, imm);
            17: return i_ins('h0C, s, t, imm);
            18: return i_ins('h0D, s, t, imm);
            19: return i_ins('h0E, s, t, imm);
            20: return i_ins('h0F, 0, t, imm);
            21: return i_ins('h23, 0, t, 4 * $urandom_range(0, 63));
            22: return i_ins('h2B, 0, t, 4 * $urandom_range(0, 63));
            23: return i_ins('h3F, s, t, imm);
            default: return r_ins(s, t, d, 0, 'h3F);
        endcase
    endfunction

    // Control transfers only jump forward and never sit in a delay slot
    task automatic gen_prog(input int n);
        bit prev_ctl;
        int tgt;
        prev_ctl = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (!prev_ctl && i < n - 1 && $urandom_range(0, 99) < 15) begin
                tgt = $urandom_range(i + 2, n);
                case ($urandom_range(0, 3))
                    0: prog[i] = i_ins('h04, rr(), rr(), tgt - i - 1);
                    1: prog[i] = i_ins('h05, rr(), rr(), tgt - i - 1);
                    2: prog[i] = j_ins('h02, tgt);
                    default: prog[i] = j_ins('h03, tgt);
                endcase
                prev_ctl = 1'b1;
            end else begin
                prog[i] = rand_plain();
                prev_ctl = 1'b0;
            end
        end
        prog[n] = r_ins(0, 0, 0, 0, 'h08);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin seed[i] = 32'h0; prog[i] = 32'h0; end

        // Basic program, mid-program reset with a JR pending, then run to halt
        prog[0] = i_ins('h0F, 0, 1, 1);
        prog[1] = i_ins('h0F, 0, 3, 4);
        prog[2] = r_ins(1, 3, 2, 0, 'h21);
        prog[3] = r_ins(0, 0, 0, 0, 'h08);
        prog[4] = i_ins('h09, 0, 0, 0);
        do_reset();
        chk("rst_pc", instr_address, BASE);
        chk("rst_v0", register_v0, 32'h0);
        chk("rst_active", 32'(active), 32'h1);
        chk("rst_strobes", 32'({data_read, data_write}), 32'h0);
        adv();
        chk("hold_until_enabled", instr_address, BASE);
        clk_enable = 1'b1;
        repeat (3) adv();
        chk("p1_v0_before_reset", register_v0, 32'h00050000);
        reset = 1'b0;
        adv();
        reset = 1'b1;
        #1;
        chk("midrst_pc", instr_address, BASE);
        chk("midrst_v0", register_v0, 32'h0);
        chk("midrst_active", 32'(active), 32'h1);
        adv();
        chk("midrst_branch_dropped", instr_address, BASE + 32'd4);
        for (int i = 0; i < 20 && instr_address != 32'h0; i++) adv();
        chk("p1_halt_pc", instr_address, 32'h0);
        chk("p1_halt_v0", register_v0, 32'h00050000);
        chk("p1_halt_active", 32'(active), 32'h0);
        repeat (2) adv();
        chk("p1_stays_halted", instr_address, 32'h0);
        chk("p1_halted_no_write", 32'(data_write), 32'h0);

        // Store/load, enable hold, delay slot, $0 writes, wrap, JALR
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = i_ins('h0D, 0, 1, 'h1234);
        prog[1]  = i_ins('h2B, 0, 1, 8);
        prog[2]  = i_ins('h23, 0, 2, 8);
        prog[3]  = i_ins('h09, 0, 0, 5);
        prog[4]  = r_ins(0, 0, 2, 0, 'h21);
        prog[5]  = i_ins('h04, 0, 0, 2);
        prog[6]  = i_ins('h09, 0, 2, 7);
        prog[7]  = i_ins('h09, 0, 2, 99);
        prog[8]  = i_ins('h09, 0, 2, -1);
        prog[9]  = i_ins('h09, 2, 2, 1);
        prog[10] = r_ins(0, 0, 2, 0, 'h09);
        do_reset();
        chk("rst_after_halt_active", 32'(active), 32'h1);
        clk_enable = 1'b1;
        adv();
        chk("sw_write", 32'(data_write), 32'h1);
        chk("sw_read", 32'(data_read), 32'h0);
        chk("sw_addr", data_address, 32'h8);
        chk("sw_data", data_writedata, 32'h1234);
        clk_enable = 1'b0;
        #1;
        chk("hold_no_write", 32'(data_write), 32'h0);
        repeat (3) begin
            adv();
            chk("hold_pc", instr_address, BASE + 32'd4);
            chk("hold_strobes", 32'({data_read, data_write}), 32'h0);
        end
        clk_enable = 1'b1;
        #1;
        chk("resume_write", 32'(data_write), 32'h1);
        adv();
        chk("lw_read", 32'(data_read), 32'h1);
        chk("lw_write", 32'(data_write), 32'h0);
        chk("lw_addr", data_address, 32'h8);
        chk("mem_word2", dmem[2], 32'h1234);
        adv();
        chk("lw_v0", register_v0, 32'h1234);
        repeat (2) adv();
        chk("zero_reg_v0", register_v0, 32'h0);
        adv();
        chk("delay_slot_pc", instr_address, BASE + 32'd24);
        adv();
        chk("branch_target_pc", instr_address, BASE + 32'd32);
        chk("delay_slot_v0", register_v0, 32'd7);
        adv();
        chk("minus_one_v0", register_v0, 32'hFFFFFFFF);
        adv();
        chk("wrap_v0", register_v0, 32'h0);
        for (int i = 0; i < 10 && instr_address != 32'h0; i++) adv();
        chk("jalr_link_v0", register_v0, BASE + 32'd48);
        chk("p2_halt_active", 32'(active), 32'h0);
        clk_enable = 1'b0;

        // Random programs in lockstep with the model, random enable gaps
        for (int p = 0; p < 20; p++) begin
            gen_prog(40);
            for (int i = 0; i < 64; i++) seed[i] = $urandom;
            do_reset();
            model_reset();
            run_check(400, 85);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
